// File: rtl/banco_escrita.sv
// banco_escrita -- write side of the 8 x LARGURA register bank.
//
// Holds the eight registers and presents them in parallel on saida0..saida7
// for the downstream 8:1 read multiplexer. Single-register writes use a
// valid/ready handshake (escrever/pronto) confirmed by a one-cycle ack pulse.
// A clear request (limpar) starts a sweep that zeroes one register per cycle,
// in index order, during which the bank is busy (ocupado) and not ready.
//
// Ports:
//   clock            rising-edge clock for all state
//   reset            synchronous active-high reset
//   escrever         write request (valid)
//   endereco[2:0]    target register index, same encoding as the read mux
//   dado[LARGURA]    write data, stored verbatim
//   limpar           clear request
//   pronto           ready, high only while idle
//   ack              one-cycle pulse following an accepted write
//   ocupado          high while a clear sweep is in progress
//   saida0..saida7   registered register contents
//
// Parameters:
//   LARGURA          register width
//   PROTEGE_R0       1: register 0 reads as zero; writes to it are acked
//                    but discarded

module banco_escrita #(
  parameter int LARGURA    = 16,
  parameter bit PROTEGE_R0 = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               escrever,
  input  logic [2:0]         endereco,
  input  logic [LARGURA-1:0] dado,
  input  logic               limpar,
  output logic               pronto,
  output logic               ack,
  output logic               ocupado,
  output logic [LARGURA-1:0] saida0,
  output logic [LARGURA-1:0] saida1,
  output logic [LARGURA-1:0] saida2,
  output logic [LARGURA-1:0] saida3,
  output logic [LARGURA-1:0] saida4,
  output logic [LARGURA-1:0] saida5,
  output logic [LARGURA-1:0] saida6,
  output logic [LARGURA-1:0] saida7
);

  typedef enum logic [0:0] {
    OCIOSO   = 1'b0,
    LIMPANDO = 1'b1
  } estado_t;

  estado_t                  r_estado;
  logic [2:0]               r_varredura;
  logic                     r_ack;
  logic                     w_aceita;
  logic [7:0][LARGURA-1:0]  w_saida;

  // A write is taken only while idle; a simultaneous clear request wins and
  // the write is dropped without an ack.
  assign w_aceita = (r_estado == OCIOSO) && escrever && !limpar;

  // Control FSM: idle / sweeping, plus the registered ack pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_varredura <= 3'd0;
      r_ack       <= 1'b0;
    end else begin
      r_ack <= w_aceita;
      case (r_estado)
        OCIOSO: begin
          if (limpar) begin
            r_estado    <= LIMPANDO;
            r_varredura <= 3'd0;
          end
        end
        LIMPANDO: begin
          // The counter wraps 7->0 naturally on the edge clearing reg 7.
          r_varredura <= r_varredura + 3'd1;
          if (r_varredura == 3'd7) begin
            r_estado <= OCIOSO;
          end
        end
        default: begin
          r_estado    <= OCIOSO;
          r_varredura <= 3'd0;
        end
      endcase
    end
  end

  // One storage register per bank entry. Each register sees its own write
  // enable and its own sweep strobe, so a not-yet-swept register keeps its
  // value until the sweep counter reaches it.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_banco
      if (PROTEGE_R0 && (gi == 0)) begin : g_zero
        assign w_saida[gi] = '0;
      end else begin : g_reg
        logic [LARGURA-1:0] r_valor;
        logic               w_escreve;
        logic               w_zera;

        assign w_escreve = w_aceita && (endereco == 3'(gi));
        assign w_zera    = (r_estado == LIMPANDO) && (r_varredura == 3'(gi));

        always_ff @(posedge clock) begin
          if (reset || w_zera) begin
            r_valor <= '0;
          end else if (w_escreve) begin
            r_valor <= dado;
          end
        end

        assign w_saida[gi] = r_valor;
      end
    end
  endgenerate

  // Status decodes straight from the state register.
  assign pronto  = (r_estado == OCIOSO);
  assign ocupado = (r_estado == LIMPANDO);
  assign ack     = r_ack;

  assign saida0 = w_saida[0];
  assign saida1 = w_saida[1];
  assign saida2 = w_saida[2];
  assign saida3 = w_saida[3];
  assign saida4 = w_saida[4];
  assign saida5 = w_saida[5];
  assign saida6 = w_saida[6];
  assign saida7 = w_saida[7];

endmodule

// File: tb/tb_banco_escrita.sv
// Testbench for banco_escrita: one unprotected and one PROTEGE_R0 instance
// driven from the same stimulus. Expected writes go into a scoreboard queue
// when driven; each ack pops one entry, applies it to the reference bank and
// checks every output of both instances.

module tb_banco_escrita;

  localparam int W = 16;

  logic          clock    = 1'b0;
  logic          reset    = 1'b1;
  logic          escrever = 1'b0;
  logic          limpar   = 1'b0;
  logic [2:0]    endereco = 3'd0;
  logic [W-1:0]  dado     = '0;

  logic          pronto, ack, ocupado;
  logic          pronto_p, ack_p, ocupado_p;
  logic [7:0][W-1:0] s;
  logic [7:0][W-1:0] sp;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_bank [8];

  typedef struct {
    logic [2:0]   a;
    logic [W-1:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_t;

  banco_escrita #(.LARGURA(W), .PROTEGE_R0(1'b0)) dut (
    .clock(clock), .reset(reset), .escrever(escrever), .endereco(endereco),
    .dado(dado), .limpar(limpar), .pronto(pronto), .ack(ack), .ocupado(ocupado),
    .saida0(s[0]), .saida1(s[1]), .saida2(s[2]), .saida3(s[3]),
    .saida4(s[4]), .saida5(s[5]), .saida6(s[6]), .saida7(s[7])
  );

  banco_escrita #(.LARGURA(W), .PROTEGE_R0(1'b1)) dut_p (
    .clock(clock), .reset(reset), .escrever(escrever), .endereco(endereco),
    .dado(dado), .limpar(limpar), .pronto(pronto_p), .ack(ack_p), .ocupado(ocupado_p),
    .saida0(sp[0]), .saida1(sp[1]), .saida2(sp[2]), .saida3(sp[3]),
    .saida4(sp[4]), .saida5(sp[5]), .saida6(sp[6]), .saida7(sp[7])
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Both instances against the reference bank; the protected one reads 0 at index 0.
  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_saida%0d", tag, i), 32'(s[i]), 32'(exp_bank[i]));
      chk($sformatf("%s_p_saida%0d", tag, i), 32'(sp[i]),
          (i == 0) ? 32'd0 : 32'(exp_bank[i]));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [W-1:0] d);
    wr_t t;
    t.a = a;
    t.d = d;
    escrever = 1'b1;
    endereco = a;
    dado     = d;
    sb.push_back(t);
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      chk("ack_p", 32'(ack_p), 32'(ack));
      if (ack) begin
        if (sb.size() == 0) begin
          chk("ack_spurious", 32'(ack), 32'd0);
        end else begin
          mon_t = sb.pop_front();
          exp_bank[mon_t.a] = mon_t.d;
          $display("ack: endereco=%0d dado=0x%04h saida=0x%04h", mon_t.a, mon_t.d, s[mon_t.a]);
          check_all($sformatf("wr%0d", mon_t.a));
        end
      end
    end
  end

  // Sweep; optionally with a write colliding with limpar on the first edge,
  // otherwise with escrever held high in the middle of the sweep.
  task automatic sweep(input bit collide);
    limpar = 1'b1;
    if (collide) begin
      escrever = 1'b1;
      endereco = 3'd2;
      dado     = 16'h1234;
    end
    tick();
    limpar   = 1'b0;
    escrever = 1'b0;
    chk("sweep_pronto0", 32'(pronto), 32'd0);
    chk("sweep_ocupado0", 32'(ocupado), 32'd1);
    check_all("sweep0");
    for (int k = 1; k <= 8; k++) begin
      if (!collide && k == 2) begin
        escrever = 1'b1;
        endereco = 3'd3;
        dado     = 16'h5555;
      end
      if (k == 7) escrever = 1'b0;
      tick();
      exp_bank[k-1] = '0;
      $display("sweep: cycle %0d pronto=%0b ocupado=%0b", k, pronto, ocupado);
      check_all($sformatf("sweep%0d", k));
      chk($sformatf("sweep%0d_pronto", k), 32'(pronto), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("sweep%0d_ocupado", k), 32'(ocupado), (k == 8) ? 32'd0 : 32'd1);
    end
    tick();
    chk("sweep_ack_low", 32'(ack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_bank[i] = '0;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_all("rst");
    chk("rst_pronto", 32'(pronto), 32'd1);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);

    // Single write
    push_wr(3'd5, 16'hBEEF);
    tick();
    escrever = 1'b0;
    tick();
    chk("single_ack_low", 32'(ack), 32'd0);
    chk("single_saida5", 32'(s[5]), 32'h0000BEEF);

    // Eight back-to-back writes
    for (int i = 0; i < 8; i++) begin
      push_wr(3'(i), W'(16'h1111 * i));
      tick();
    end
    escrever = 1'b0;
    tick();
    tick();
    chk("b2b_ack_low", 32'(ack), 32'd0);

    // Preload 0xFFFF, then sweep with a mid-sweep write attempt
    for (int i = 0; i < 8; i++) begin
      push_wr(3'(i), 16'hFFFF);
      tick();
    end
    escrever = 1'b0;
    tick();
    tick();
    sweep(1'b0);

    // Write and limpar on the same edge
    push_wr(3'd2, 16'h7777);
    tick();
    escrever = 1'b0;
    tick();
    tick();
    sweep(1'b1);
    chk("collide_saida2", 32'(s[2]), 32'd0);

    // Reset in the 4th sweep cycle
    push_wr(3'd1, 16'hABCD);
    tick();
    push_wr(3'd6, 16'h1357);
    tick();
    escrever = 1'b0;
    tick();
    tick();
    limpar = 1'b1;
    tick();
    limpar = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_bank[k-1] = '0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_bank[i] = '0;
    check_all("midrst");
    chk("midrst_pronto", 32'(pronto), 32'd1);
    chk("midrst_ocupado", 32'(ocupado), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);

    // Write to register 0: protected instance acks but keeps 0
    push_wr(3'd0, 16'hAAAA);
    tick();
    escrever = 1'b0;
    tick();
    chk("prot_saida0", 32'(sp[0]), 32'd0);
    chk("unprot_saida0", 32'(s[0]), 32'h0000AAAA);

    tick();
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/banco_escrita.md
Name: banco_escrita

Overview:
- Write side of the 8 x 16-bit register bank: holds the eight registers and drives them in parallel as saida0..saida7.
- These outputs feed the bank's 8:1 read multiplexador, which selects one with a 3-bit controle.
- Accepts single-register writes through a valid/ready handshake.
- Provides a sequenced clear that zeroes the bank one register per cycle.

Parameters:
- LARGURA, 16, data width of each register and of dado/saidaN.
- PROTEGE_R0, 0, when 1: register 0 is hardwired to zero, writes to endereco 0 are discarded but still acknowledged.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- escrever  input  1  write request (valid).
- endereco  input  3  target register index 0..7, same encoding as the read mux controle.
- dado  input  LARGURA  write data.
- limpar  input  1  clear request.
- pronto  output  1  ready; high only in state OCIOSO.
- ack  output  1  one-cycle pulse confirming an accepted write.
- ocupado  output  1  high while a clear sweep is in progress.
- saida0..saida7  output  LARGURA each  current register contents, registered outputs.

Behaviour:
- Reset (sampled on clock edge, reset=1):
  - all registers 0; state OCIOSO; varredura counter 0.
  - ack=0, ocupado=0; pronto=1 from the first cycle after reset.
  - Reset overrides everything, including mid-clear; a partially cleared bank becomes fully zero.
- States: OCIOSO, LIMPANDO.
- OCIOSO:
  - pronto=1, ocupado=0.
  - Write accepted on an edge where escrever=1, pronto=1, limpar=0.
  - reg[endereco] <= dado; new value visible on saidaN the cycle after the accepting edge (1-cycle latency).
  - ack=1 for exactly the cycle following acceptance; otherwise 0.
  - Back-to-back writes allowed every cycle, each with its own ack pulse.
  - Same address written twice in a row: the last write wins.
- limpar=1 in OCIOSO:
  - go to LIMPANDO; counter=0; no register modified on this edge.
  - If escrever=1 on the same edge, limpar wins: the write is dropped and no ack is produced.
- LIMPANDO:
  - pronto=0, ocupado=1.
  - Each edge: reg[counter] <= 0, counter++.
  - On the edge clearing reg[7], return to OCIOSO, counter wraps to 0.
  - Total 8 cycles in LIMPANDO; pronto returns high on the 9th cycle after the edge that sampled limpar.
  - escrever and limpar are ignored in LIMPANDO; no ack is generated.
  - Registers not yet swept keep their old values until reached.
- PROTEGE_R0=1:
  - saida0 is constant 0.
  - A write to endereco 0 is accepted and acked, with no effect.
- Widths: dado is stored verbatim; no arithmetic. Counter is 3 bits, wrapping 7->0.
- No combinational path from inputs to saidaN or ack.
- pronto and ocupado decode from state only.

Test Plan:
- Reset, then release -> all saidaN=0x0000, pronto=1, ack=0, ocupado=0.
- Write endereco=5, dado=0xBEEF -> saida5=0xBEEF one cycle later; ack high exactly one cycle; other outputs unchanged.
- Eight back-to-back writes, endereco i, dado=0x1111*i -> eight consecutive ack pulses; saidaN=0x1111*N.
- Preload all registers with 0xFFFF, pulse limpar:
  - pronto=0 and ocupado=1 for 8 cycles.
  - saida0..saida7 drop to 0 one per cycle, in order.
  - escrever asserted mid-sweep has no effect and gives no ack.
  - pronto=1 afterwards.
- escrever=1 (endereco 2, dado=0x1234) and limpar=1 on the same edge -> no ack; saida2 ends at 0 after the sweep.
- Reset asserted on the 4th LIMPANDO cycle -> next cycle all saidaN=0, state OCIOSO, pronto=1.
- PROTEGE_R0=1 build: write 0xAAAA to endereco 0 -> ack pulses; saida0 stays 0x0000.
